// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx - serial receive half of the UART.
//
// Deserialises 8N1-style frames (DATA_BITS payload bits, LSB first, one stop
// bit) from the asynchronous rx pin. It uses the OVERSAMPLE-per-bit tick
// (rxclk_en) from the baud rate generator, and samples each bit at its centre.
//
// Parameters
//   DATA_BITS   payload bits per frame (>= 2)
//   OVERSAMPLE  rxclk_en ticks per bit period (even, >= 4)
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   rxclk_en     in   single-cycle oversample tick
//   rx           in   serial line, idle high, asynchronous to clk
//   rdy_clr      in   consumer has read data; clears rdy and overrun
//   data         out  last good received byte
//   rdy          out  data holds an unread byte
//   framing_err  out  last completed frame had its stop bit sampled low
//   overrun      out  sticky: a good frame completed while rdy was already set
//   busy         out  receiver is anywhere other than idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rxclk_en,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Centre of the start bit is half a bit after the falling edge; every
    // later sample point is a whole bit further on.
    localparam logic [SW-1:0] CNT_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] CNT_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_STOP     = 3'd3,
        ST_BRK_WAIT = 3'd4
    } state_e;

    state_e                 state_q,      state_d;
    logic [SW-1:0]          sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]          bit_idx_q,    bit_idx_d;
    logic [DATA_BITS-1:0]   shift_reg_q,  shift_reg_d;
    logic [DATA_BITS-1:0]   data_q,       data_d;
    logic                   rdy_q,        rdy_d;
    logic                   framing_err_q, framing_err_d;
    logic                   overrun_q,    overrun_d;
    logic                   busy_q,       busy_d;
    logic                   rx_meta_q,    rx_meta_d;
    logic                   rx_s_q,       rx_s_d;

    // Next-state logic: synchroniser, receive FSM, counters and status flags.
    always_comb begin
        rx_meta_d     = rx;
        rx_s_d        = rx_meta_q;
        state_d       = state_q;
        sample_cnt_d  = sample_cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_reg_d   = shift_reg_q;
        data_d        = data_q;
        framing_err_d = framing_err_q;

        // The consumer's acknowledge acts on every clk; a good-frame update
        // below overrides it so a coincident set always wins.
        if (rdy_clr) begin
            rdy_d     = 1'b0;
            overrun_d = 1'b0;
        end else begin
            rdy_d     = rdy_q;
            overrun_d = overrun_q;
        end

        if (rxclk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_d      = ST_START;
                        sample_cnt_d = {SW{1'b0}};
                    end else begin
                        state_d      = ST_IDLE;
                    end
                end

                ST_START: begin
                    if (sample_cnt_q == CNT_MID) begin
                        sample_cnt_d = {SW{1'b0}};
                        bit_idx_d    = {BW{1'b0}};
                        // Line back high by mid start bit: a glitch, not a frame.
                        if (rx_s_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SW'(1);
                    end
                end

                ST_DATA: begin
                    if (sample_cnt_q == CNT_LAST) begin
                        // Right shift: the first (LSB) bit ends up at bit 0.
                        shift_reg_d  = {rx_s_q, shift_reg_q[DATA_BITS-1:1]};
                        sample_cnt_d = {SW{1'b0}};
                        if (bit_idx_q == BIT_LAST) begin
                            bit_idx_d = {BW{1'b0}};
                            state_d   = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + BW'(1);
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SW'(1);
                    end
                end

                ST_STOP: begin
                    if (sample_cnt_q == CNT_LAST) begin
                        sample_cnt_d = {SW{1'b0}};
                        if (rx_s_q) begin
                            data_d        = shift_reg_q;
                            rdy_d         = 1'b1;
                            framing_err_d = 1'b0;
                            if (rdy_q && !rdy_clr) begin
                                overrun_d = 1'b1;
                            end else begin
                                overrun_d = overrun_d;
                            end
                            state_d = ST_IDLE;
                        end else begin
                            framing_err_d = 1'b1;
                            state_d       = ST_BRK_WAIT;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SW'(1);
                    end
                end

                // A break or stuck-low line must not look like a new start bit.
                ST_BRK_WAIT: begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BRK_WAIT;
                    end
                end

                default: begin
                    state_d      = ST_IDLE;
                    sample_cnt_d = {SW{1'b0}};
                    bit_idx_d    = {BW{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset puts the line synchroniser at idle-high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            sample_cnt_q  <= {SW{1'b0}};
            bit_idx_q     <= {BW{1'b0}};
            shift_reg_q   <= {DATA_BITS{1'b0}};
            data_q        <= {DATA_BITS{1'b0}};
            rdy_q         <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            sample_cnt_q  <= sample_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_reg_q   <= shift_reg_d;
            data_q        <= data_d;
            rdy_q         <= rdy_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
        end
    end

    assign data        = data_q;
    assign rdy         = rdy_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx - self-checking bench for uart_rx.
// A frame-level model tracks what the consumer should see (last good byte,
// ready, overrun, framing error). Frames are generated bit by bit at a
// programmable tick divider.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OS = 16;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       rxclk_en = 1'b0;
    logic       rx       = 1'b1;
    logic       rdy_clr  = 1'b0;
    logic [7:0] data;
    logic       rdy;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int tick_div = 1;
    int tick_cnt = 0;

    // Frame-level reference model.
    logic [7:0] exp_data = 8'h00;
    logic       exp_rdy  = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_ovr  = 1'b0;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rxclk_en    (rxclk_en),
        .rx          (rx),
        .rdy_clr     (rdy_clr),
        .data        (data),
        .rdy         (rdy),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Oversample tick: one clk high out of every tick_div.
    always @(negedge clk) begin
        if (tick_cnt >= tick_div - 1) begin
            tick_cnt = 0;
            rxclk_en = 1'b1;
        end else begin
            tick_cnt = tick_cnt + 1;
            rxclk_en = 1'b0;
        end
    end

    task automatic model_good(input logic [7:0] b);
        if (exp_rdy) exp_ovr = 1'b1;
        exp_rdy  = 1'b1;
        exp_data = b;
        exp_ferr = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_val);
        int bc;
        bc = OS * tick_div;
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bc) @(negedge clk);
        end
        rx = stop_val;
        repeat (bc) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * OS * tick_div) @(negedge clk);
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
        exp_rdy = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
        total++; if (framing_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", framing_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        tick_div = 1;
        drive_frame(8'h55, 1'b1);
        model_good(8'h55);
        idle_bits(1);
        total++; if (data !== exp_data) begin bad++; $display("FAIL basic_data got=%h exp=%h", data, exp_data); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL basic_rdy got=%b exp=1", rdy); end
        total++; if (framing_err !== 1'b0) begin bad++; $display("FAIL basic_ferr got=%b exp=0", framing_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL basic_ovr got=%b exp=0", overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy); end
        pulse_clr();
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL basic_clr_rdy got=%b exp=0", rdy); end
    endtask

    task automatic test_back_to_back();
        tick_div = 27;
        drive_frame(8'hA3, 1'b1);
        model_good(8'hA3);
        drive_frame(8'h0F, 1'b1);
        model_good(8'h0F);
        idle_bits(1);
        total++; if (data !== exp_data) begin bad++; $display("FAIL b2b_data got=%h exp=%h", data, exp_data); end
        total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL b2b_rdy got=%b exp=%b", rdy, exp_rdy); end
        total++; if (overrun !== exp_ovr) begin bad++; $display("FAIL b2b_ovr got=%b exp=%b", overrun, exp_ovr); end
        pulse_clr();
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL b2b_clr_rdy got=%b exp=0", rdy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_clr_ovr got=%b exp=0", overrun); end
    endtask

    task automatic test_glitch();
        tick_div = 2;
        rx = 1'b0;
        repeat (5 * tick_div) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_during got=%b exp=1", busy); end
        rx = 1'b1;
        repeat (2 * OS * tick_div) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_after got=%b exp=0", busy); end
        total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL glitch_rdy got=%b exp=%b", rdy, exp_rdy); end
        total++; if (framing_err !== exp_ferr) begin bad++; $display("FAIL glitch_ferr got=%b exp=%b", framing_err, exp_ferr); end
        total++; if (data !== exp_data) begin bad++; $display("FAIL glitch_data got=%h exp=%h", data, exp_data); end
        drive_frame(8'h81, 1'b1);
        model_good(8'h81);
        idle_bits(1);
        total++; if (data !== exp_data) begin bad++; $display("FAIL glitch_next_data got=%h exp=%h", data, exp_data); end
        total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL glitch_next_rdy got=%b exp=%b", rdy, exp_rdy); end
        pulse_clr();
    endtask

    task automatic test_framing();
        tick_div = 2;
        drive_frame(8'h3C, 1'b0);
        exp_ferr = 1'b1;
        repeat (40 * tick_div) @(negedge clk);
        total++; if (framing_err !== 1'b1) begin bad++; $display("FAIL ferr_flag got=%b exp=1", framing_err); end
        total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL ferr_rdy got=%b exp=%b", rdy, exp_rdy); end
        total++; if (data !== exp_data) begin bad++; $display("FAIL ferr_data got=%h exp=%h", data, exp_data); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_low got=%b exp=1", busy); end
        idle_bits(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_high got=%b exp=0", busy); end
        drive_frame(8'h7E, 1'b1);
        model_good(8'h7E);
        idle_bits(1);
        total++; if (data !== exp_data) begin bad++; $display("FAIL ferr_next_data got=%h exp=%h", data, exp_data); end
        total++; if (framing_err !== exp_ferr) begin bad++; $display("FAIL ferr_next_flag got=%b exp=%b", framing_err, exp_ferr); end
        pulse_clr();
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop_ok;
        for (int n = 0; n < 8; n++) begin
            tick_div = $urandom_range(1, 4);
            b        = 8'($urandom);
            stop_ok  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) pulse_clr();
            drive_frame(b, stop_ok);
            if (stop_ok) model_good(b);
            else exp_ferr = 1'b1;
            idle_bits(1);
            total++; if (data !== exp_data) begin bad++; $display("FAIL rand%0d_data got=%h exp=%h", n, data, exp_data); end
            total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL rand%0d_rdy got=%b exp=%b", n, rdy, exp_rdy); end
            total++; if (framing_err !== exp_ferr) begin bad++; $display("FAIL rand%0d_ferr got=%b exp=%b", n, framing_err, exp_ferr); end
            total++; if (overrun !== exp_ovr) begin bad++; $display("FAIL rand%0d_ovr got=%b exp=%b", n, overrun, exp_ovr); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand%0d_busy got=%b exp=0", n, busy); end
        end
    endtask

    // With a tick on every clk the mid-stop sample lands on the 155th edge
    // after the falling edge: 2 synchroniser edges, the detecting tick,
    // OS/2 ticks to mid start, 8*OS data ticks and OS stop ticks.
    task automatic test_clr_collision();
        logic [7:0] b;
        tick_div = 1;
        drive_frame(8'h11, 1'b1); model_good(8'h11); idle_bits(1);
        drive_frame(8'h22, 1'b1); model_good(8'h22); idle_bits(1);
        b = 8'($urandom) ^ 8'h22;
        fork
            drive_frame(b, 1'b1);
            begin
                repeat (154) @(negedge clk);
                total++; if (rdy !== 1'b1) begin bad++; $display("FAIL coll_pre_rdy got=%b exp=1", rdy); end
                total++; if (overrun !== 1'b1) begin bad++; $display("FAIL coll_pre_ovr got=%b exp=1", overrun); end
                total++; if (data !== exp_data) begin bad++; $display("FAIL coll_pre_data got=%h exp=%h", data, exp_data); end
                rdy_clr = 1'b1;
                @(negedge clk);
                rdy_clr = 1'b0;
                exp_rdy  = 1'b1;
                exp_ovr  = 1'b0;
                exp_data = b;
                exp_ferr = 1'b0;
                total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL coll_rdy got=%b exp=%b", rdy, exp_rdy); end
                total++; if (overrun !== exp_ovr) begin bad++; $display("FAIL coll_ovr got=%b exp=%b", overrun, exp_ovr); end
                total++; if (data !== exp_data) begin bad++; $display("FAIL coll_data got=%h exp=%h", data, exp_data); end
            end
        join
        idle_bits(1);
    endtask

    task automatic test_reset_mid_frame();
        tick_div = 2;
        fork
            drive_frame(8'($urandom), 1'b1);
            begin
                repeat (4 * OS * tick_div + 5) @(negedge clk);
                #2 reset_n = 1'b0;
                #1;
                total++; if (data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h exp=00", data); end
                total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rstmid_rdy got=%b exp=0", rdy); end
                total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rstmid_ovr got=%b exp=0", overrun); end
                total++; if (framing_err !== 1'b0) begin bad++; $display("FAIL rstmid_ferr got=%b exp=0", framing_err); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
            end
        join
        exp_data = 8'h00; exp_rdy = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        idle_bits(1);
        drive_frame(8'hC5, 1'b1);
        model_good(8'hC5);
        idle_bits(1);
        total++; if (data !== exp_data) begin bad++; $display("FAIL rstmid_next_data got=%h exp=%h", data, exp_data); end
        total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL rstmid_next_rdy got=%b exp=%b", rdy, exp_rdy); end
        total++; if (overrun !== exp_ovr) begin bad++; $display("FAIL rstmid_next_ovr got=%b exp=%b", overrun, exp_ovr); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_random();
        test_clr_collision();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
